// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared types, constants and helpers for the instruction realigner
package common_pkg;

    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        HALF    = 2'd1,
        SKIP_LO = 2'd2
    } realign_state_t;

    // RV32C: any halfword whose two low bits are not 2'b11 is a 16-bit instruction
    function automatic logic is_compressed(input logic [HALF_W-1:0] h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_realigner.sv
// rtl/instr_realigner.sv - splits/reassembles fetch words into RV32C instructions; optional REALIGNER_PERF_EN counters
module instr_realigner
    import common_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
`ifdef REALIGNER_PERF_EN
    output logic [31:0] perf_c_cnt,
    output logic [31:0] perf_i_cnt,
`endif
    output logic        out_is_c
);

    localparam realign_state_t RESET_STATE = RESET_PC[1] ? SKIP_LO : ALIGNED;

    realign_state_t    state_q, state_d;
    logic [HALF_W-1:0] hold_q, hold_d;
    logic [31:0]       hold_pc_q, hold_pc_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [31:0]       out_pc_q, out_pc_d;
    logic              out_is_c_q, out_is_c_d;
    logic              fetch_ready_c;
    logic              adv;
    logic [31:0]       word_pc;
    logic              unused_addr_lsbs;

    // Low address bits carry no information: fetch words are word aligned, targets halfword aligned
    assign unused_addr_lsbs = ^{fetch_pc[1:0], flush_pc[0]};

    assign adv     = !out_valid_q || out_ready;
    assign word_pc = {fetch_pc[31:2], 2'b00};

    // Next-state, hold register and output-stage load decisions
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_pc_d     = hold_pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        out_is_c_d    = out_is_c_q;
        fetch_ready_c = 1'b0;

        if (flush) begin
            out_valid_d = 1'b0;
            hold_d      = '0;
            hold_pc_d   = {flush_pc[31:1], 1'b0};
            state_d     = flush_pc[1] ? SKIP_LO : ALIGNED;
        end else begin
            // An accepted or empty output slot is vacated unless refilled below
            if (adv) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                ALIGNED: begin
                    fetch_ready_c = adv;
                    if (fetch_valid && adv) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = word_pc;
                        if (is_compressed(fetch_data[15:0])) begin
                            out_instr_d = {16'h0, fetch_data[15:0]};
                            out_is_c_d  = 1'b1;
                            hold_d      = fetch_data[31:16];
                            hold_pc_d   = word_pc + 32'd2;
                            state_d     = HALF;
                        end else begin
                            out_instr_d = fetch_data;
                            out_is_c_d  = 1'b0;
                        end
                    end
                end
                HALF: begin
                    if (is_compressed(hold_q)) begin
                        // Upper halfword is a complete instruction; no new word needed yet
                        if (adv) begin
                            out_valid_d = 1'b1;
                            out_instr_d = {16'h0, hold_q};
                            out_pc_d    = hold_pc_q;
                            out_is_c_d  = 1'b1;
                            state_d     = ALIGNED;
                        end
                    end else begin
                        // Straddling instruction: low half of the next word completes it
                        fetch_ready_c = adv;
                        if (fetch_valid && adv) begin
                            out_valid_d = 1'b1;
                            out_instr_d = {fetch_data[15:0], hold_q};
                            out_pc_d    = hold_pc_q;
                            out_is_c_d  = 1'b0;
                            hold_d      = fetch_data[31:16];
                            hold_pc_d   = word_pc + 32'd2;
                        end
                    end
                end
                SKIP_LO: begin
                    fetch_ready_c = adv;
                    if (fetch_valid && adv) begin
                        hold_d    = fetch_data[31:16];
                        hold_pc_d = word_pc + 32'd2;
                        state_d   = HALF;
                    end
                end
                default: begin
                    state_d = ALIGNED;
                end
            endcase
        end
    end

    // State, hold and output-stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            hold_q      <= '0;
            hold_pc_q   <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= RESET_PC;
            out_is_c_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_pc_q   <= hold_pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_is_c_q  <= out_is_c_d;
        end
    end

    assign fetch_ready = fetch_ready_c;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign out_is_c    = out_is_c_q;

`ifdef REALIGNER_PERF_EN
    logic [31:0] perf_c_cnt_q, perf_c_cnt_d;
    logic [31:0] perf_i_cnt_q, perf_i_cnt_d;
    logic        accept;

    // A flush drops the pending instruction, so it is not counted as accepted
    assign accept = out_valid_q && out_ready && !flush;

    // Count accepted instructions by width; counters wrap naturally
    always_comb begin
        perf_c_cnt_d = perf_c_cnt_q;
        perf_i_cnt_d = perf_i_cnt_q;
        if (accept) begin
            if (out_is_c_q) begin
                perf_c_cnt_d = perf_c_cnt_q + 32'd1;
            end else begin
                perf_i_cnt_d = perf_i_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_c_cnt_q <= '0;
            perf_i_cnt_q <= '0;
        end else begin
            perf_c_cnt_q <= perf_c_cnt_d;
            perf_i_cnt_q <= perf_i_cnt_d;
        end
    end

    assign perf_c_cnt = perf_c_cnt_q;
    assign perf_i_cnt = perf_i_cnt_q;
`endif

endmodule

// File: tb/tb_instr_realigner.sv
// tb/tb_instr_realigner.sv - self-checking bench for instr_realigner (vector table plus scoreboard)
module tb_instr_realigner;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic [31:0] fetch_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_is_c;
`ifdef REALIGNER_PERF_EN
    logic [31:0] perf_c_cnt;
    logic [31:0] perf_i_cnt;
    int          model_c_cnt = 0;
    int          model_i_cnt = 0;
`endif

    instr_realigner #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .fetch_pc    (fetch_pc),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
`ifdef REALIGNER_PERF_EN
        .perf_c_cnt  (perf_c_cnt),
        .perf_i_cnt  (perf_i_cnt),
`endif
        .out_is_c    (out_is_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_c;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        int          n_exp;
        exp_t        e0;
        exp_t        e1;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   fetch_hs  = 0;
    logic bp_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %08h, required %08h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p, input logic c);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        e.is_c  = c;
        return e;
    endfunction

    // Scoreboard: compare each accepted instruction against the oldest expectation
    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (fetch_valid && fetch_ready) fetch_hs++;
            if (out_valid && out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_out: got %08h @%08h c=%0b, required nothing", out_instr, out_pc, out_is_c);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_instr === e.instr && out_pc === e.pc && out_is_c === e.is_c) pass_cnt++;
                    else $display("FAIL out_seq: got %08h @%08h c=%0b, required %08h @%08h c=%0b",
                                  out_instr, out_pc, out_is_c, e.instr, e.pc, e.is_c);
                end
`ifdef REALIGNER_PERF_EN
                if (out_is_c) model_c_cnt++;
                else model_i_cnt++;
`endif
            end
        end
    end

    // Random backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_word(input logic [31:0] d, input logic [31:0] p, input string name);
        int n;
        int hs0;
        hs0         = fetch_hs;
        fetch_valid = 1'b1;
        fetch_data  = d;
        fetch_pc    = p;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fetch_ready && n < 200);
        if (!fetch_ready) begin
            total_cnt++;
            $display("FAIL %s_timeout: fetch_ready never rose, got 0, required 1", name);
        end
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        check({name, "_fetch_hs"}, 32'(fetch_hs - hs0), 32'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic run_table(input logic [31:0] off, input string tag);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(vecs[i].e0.instr, vecs[i].e0.pc + off, vecs[i].e0.is_c));
            if (vecs[i].n_exp == 2) exp_q.push_back(mk(vecs[i].e1.instr, vecs[i].e1.pc + off, vecs[i].e1.is_c));
            drive_word(vecs[i].data, vecs[i].pc + off, $sformatf("%s_w%0d", tag, i));
        end
        drain(tag);
    endtask

    function automatic vec_t mv(input logic [31:0] d, input logic [31:0] p, input int n, input exp_t a, input exp_t b);
        vec_t v;
        v.data  = d;
        v.pc    = p;
        v.n_exp = n;
        v.e0    = a;
        v.e1    = b;
        return v;
    endfunction

    initial begin
        exp_t none;
        none = mk(32'h0, 32'h0, 1'b0);
        vecs[0] = mv(32'h4501_4085, 32'h100, 2, mk(32'h0000_4085, 32'h100, 1'b1), mk(32'h0000_4501, 32'h102, 1'b1));
        vecs[1] = mv(32'h0050_0093, 32'h104, 1, mk(32'h0050_0093, 32'h104, 1'b0), none);
        vecs[2] = mv(32'h0093_4085, 32'h108, 1, mk(32'h0000_4085, 32'h108, 1'b1), none);
        vecs[3] = mv(32'h1234_0050, 32'h10C, 2, mk(32'h0050_0093, 32'h10A, 1'b0), mk(32'h0000_1234, 32'h10E, 1'b1));
        vecs[4] = mv(32'h0000_1117, 32'h110, 1, mk(32'h0000_1117, 32'h110, 1'b0), none);
        vecs[5] = mv(32'h0013_0001, 32'h114, 1, mk(32'h0000_0001, 32'h114, 1'b1), none);
        vecs[6] = mv(32'h0293_0000, 32'h118, 1, mk(32'h0000_0013, 32'h116, 1'b0), none);
        vecs[7] = mv(32'h8082_0005, 32'h11C, 2, mk(32'h0005_0293, 32'h11A, 1'b0), mk(32'h0000_8082, 32'h11E, 1'b1));

        rst         = 1'b1;
        fetch_valid = 1'b0;
        fetch_data  = '0;
        fetch_pc    = '0;
        flush       = 1'b0;
        flush_pc    = '0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_is_c", {31'b0, out_is_c}, 32'd0);
        check("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Vector table, full throughput
        do_flush(32'h100);
        run_table(32'h0, "tab");

        // Same table under random backpressure
        do_flush(32'h1100);
        bp_en = 1'b1;
        run_table(32'h1000, "bp");
        bp_en     = 1'b0;
        out_ready = 1'b1;

        // Backpressure holds the output stage and blocks fetch
        do_flush(32'h300);
        out_ready = 1'b0;
        exp_q.push_back(mk(32'h0050_0093, 32'h300, 1'b0));
        exp_q.push_back(mk(32'h0000_0001, 32'h304, 1'b1));
        drive_word(32'h0050_0093, 32'h300, "hold_w0");
        fetch_valid = 1'b1;
        fetch_data  = 32'h0013_0001;
        fetch_pc    = 32'h304;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold_valid_%0d", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("hold_instr_%0d", i), out_instr, 32'h0050_0093);
            check($sformatf("hold_pc_%0d", i), out_pc, 32'h300);
            check($sformatf("hold_fready_%0d", i), {31'b0, fetch_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_word(32'h0013_0001, 32'h304, "hold_w1");
        drain("hold");

        // Pending instruction dropped by flush; fetch in flush cycle not consumed; redirect to 0x402
        out_ready = 1'b0;
        drive_word(32'h0293_0000, 32'h308, "drop_w");
        flush       = 1'b1;
        flush_pc    = 32'h402;
        fetch_valid = 1'b1;
        fetch_data  = 32'hDEAD_BEEF;
        fetch_pc    = 32'h500;
        @(negedge clk);
        check("flush_fready", {31'b0, fetch_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        out_ready   = 1'b1;
        @(negedge clk);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(32'h0000_0001, 32'h402, 1'b1));
        drive_word(32'h0001_ABCD, 32'h400, "redir_w");
        drain("redir");

        // Reset in the middle of a straddle
        exp_q.push_back(mk(32'h0000_4085, 32'h404, 1'b1));
        drive_word(32'h0093_4085, 32'h404, "mid_w");
        drain("mid");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef REALIGNER_PERF_EN
        model_c_cnt = 0;
        model_i_cnt = 0;
`endif
        @(negedge clk);
        check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mrst_out_pc", out_pc, 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(32'h0050_0093, 32'h0, 1'b0));
        drive_word(32'h0050_0093, 32'h0, "post_rst_w");
        drain("post_rst");

`ifdef REALIGNER_PERF_EN
        @(negedge clk);
        check("perf_c_cnt", perf_c_cnt, 32'(model_c_cnt));
        check("perf_i_cnt", perf_i_cnt, 32'(model_i_cnt));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
